// File: rtl/studio2_mem_arbiter_if.sv
// Studio II memory sequencer bus: loader, video and CPU requesters
// together with the single-port RAM macro side.
interface studio2_mem_arbiter_if #(
    parameter int unsigned AW = 12
);
    logic          ld_en;
    logic [7:0]    ld_index;
    logic          ld_wr;
    logic [15:0]   ld_addr;
    logic [7:0]    ld_din;
    logic          vid_rd;
    logic [7:0]    vid_addr;
    logic [7:0]    vid_dout;
    logic          vid_ack;
    logic          cpu_rd;
    logic          cpu_wr;
    logic [15:0]   cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;
    logic          cpu_wait_n;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic          ovf;

    modport master (
        input  ld_en, ld_index, ld_wr, ld_addr, ld_din,
        input  vid_rd, vid_addr,
        output vid_dout, vid_ack,
        input  cpu_rd, cpu_wr, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack, cpu_wait_n,
        output mem_ce, mem_we, mem_addr, mem_din,
        input  mem_dout,
        output ovf
    );

    modport slave (
        output ld_en, ld_index, ld_wr, ld_addr, ld_din,
        output vid_rd, vid_addr,
        input  vid_dout, vid_ack,
        output cpu_rd, cpu_wr, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack, cpu_wait_n,
        input  mem_ce, mem_we, mem_addr, mem_din,
        output mem_dout,
        input  ovf
    );
endinterface

// File: rtl/studio2_mem_arbiter.sv
// Studio II single-port RAM sequencer: fixed-priority LD > VID > CPU
// arbitration, console address map and CPU WAIT_N stall generation.
module studio2_mem_arbiter #(
    parameter int unsigned AW       = 12,
    parameter logic [7:0]  UNMAPPED = 8'hFF
) (
    input logic                   clk_sys,
    input logic                   reset_n,
    studio2_mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_CAP
    } state_e;

    typedef enum logic [1:0] {
        OWN_LD,
        OWN_VID,
        OWN_CPU
    } own_e;

    state_e        state_q, state_d;
    own_e          own_q, own_d;

    logic          ld_flag_q, ld_flag_d;
    logic [AW-1:0] ld_addr_q, ld_addr_d;
    logic [7:0]    ld_din_q, ld_din_d;
    logic          vid_flag_q, vid_flag_d;
    logic [7:0]    vid_addr_q, vid_addr_d;
    logic          cpu_flag_q, cpu_flag_d;
    logic [15:0]   cpu_addr_q, cpu_addr_d;
    logic [7:0]    cpu_din_q, cpu_din_d;
    logic          cpu_we_q, cpu_we_d;

    logic          mem_ce_q, mem_ce_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic          rd_q, rd_d;
    logic          unm_q, unm_d;

    logic [7:0]    vid_dout_q, vid_dout_d;
    logic          vid_ack_q, vid_ack_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ovf_q, ovf_d;

    logic          ld_stb, vid_stb, cpu_stb;
    logic [15:0]   ld_base;
    logic [AW-1:0] ld_now;
    logic          ld_req, vid_req, cpu_req;
    logic [AW-1:0] ld_a;
    logic [7:0]    ld_d;
    logic [7:0]    vid_a;
    logic [15:0]   cpu_a;
    logic [7:0]    cpu_d;
    logic          cpu_w;
    logic          cpu_map, cpu_ram, cpu_ce;
    logic [11:0]   cpu_a12;
    logic [AW-1:0] cpu_maddr;
    logic          idle;
    logic          gnt_ld, gnt_vid, gnt_cpu;

    assign ld_stb  = bus.ld_en & bus.ld_wr;
    assign vid_stb = bus.vid_rd;
    assign cpu_stb = bus.cpu_rd | bus.cpu_wr;

    assign ld_base = (bus.ld_index == 8'd0) ? bus.ld_addr
                                            : bus.ld_addr + 16'h0400;
    assign ld_now  = AW'(ld_base);

    // A held request always beats a fresh strobe from the same source
    assign ld_req  = ld_flag_q | ld_stb;
    assign vid_req = vid_flag_q | vid_stb;
    assign cpu_req = cpu_flag_q | cpu_stb;

    assign ld_a  = ld_flag_q ? ld_addr_q : ld_now;
    assign ld_d  = ld_flag_q ? ld_din_q : bus.ld_din;
    assign vid_a = vid_flag_q ? vid_addr_q : bus.vid_addr;
    assign cpu_a = cpu_flag_q ? cpu_addr_q : bus.cpu_addr;
    assign cpu_d = cpu_flag_q ? cpu_din_q : bus.cpu_din;
    assign cpu_w = cpu_flag_q ? cpu_we_q : bus.cpu_wr;

    assign cpu_map   = (cpu_a[15:12] == 4'h0);
    assign cpu_ram   = (cpu_a[11:9] == 3'b100) || (cpu_a[11:9] == 3'b110);
    assign cpu_ce    = cpu_map && (!cpu_w || cpu_ram);
    assign cpu_a12   = (cpu_a[11:9] == 3'b110) ? (cpu_a[11:0] & 12'h9FF)
                                               : cpu_a[11:0];
    assign cpu_maddr = AW'(cpu_a12);

    assign idle    = (state_q == S_IDLE);
    assign gnt_ld  = idle && ld_req;
    assign gnt_vid = idle && !ld_req && !bus.ld_en && vid_req;
    assign gnt_cpu = idle && !ld_req && !bus.ld_en && !vid_req && cpu_req;

    always_comb begin
        ld_flag_d  = gnt_ld ? (ld_stb && ld_flag_q) : (ld_flag_q || ld_stb);
        vid_flag_d = gnt_vid ? (vid_stb && vid_flag_q)
                             : (vid_flag_q || vid_stb);
        cpu_flag_d = gnt_cpu ? (cpu_stb && cpu_flag_q)
                             : (cpu_flag_q || cpu_stb);
        ld_addr_d  = ld_addr_q;
        ld_din_d   = ld_din_q;
        vid_addr_d = vid_addr_q;
        cpu_addr_d = cpu_addr_q;
        cpu_din_d  = cpu_din_q;
        cpu_we_d   = cpu_we_q;
        ovf_d      = ovf_q;
        if (ld_stb && (!ld_flag_q || gnt_ld)) begin
            ld_addr_d = ld_now;
            ld_din_d  = bus.ld_din;
        end
        if (vid_stb && (!vid_flag_q || gnt_vid)) begin
            vid_addr_d = bus.vid_addr;
        end
        if (cpu_stb && (!cpu_flag_q || gnt_cpu)) begin
            cpu_addr_d = bus.cpu_addr;
            cpu_din_d  = bus.cpu_din;
            cpu_we_d   = bus.cpu_wr;
        end
        // A strobe colliding with its own un-granted pending slot is lost
        if ((ld_stb && ld_flag_q && !gnt_ld) ||
            (vid_stb && vid_flag_q && !gnt_vid) ||
            (cpu_stb && cpu_flag_q && !gnt_cpu)) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        mem_ce_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        rd_d       = rd_q;
        unm_d      = unm_q;
        vid_dout_d = vid_dout_q;
        vid_ack_d  = 1'b0;
        cpu_dout_d = cpu_dout_q;
        cpu_ack_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                unique case (1'b1)
                    gnt_ld: begin
                        own_d      = OWN_LD;
                        mem_ce_d   = 1'b1;
                        mem_we_d   = 1'b1;
                        mem_addr_d = ld_a;
                        mem_din_d  = ld_d;
                        rd_d       = 1'b0;
                        unm_d      = 1'b0;
                        state_d    = S_ACC;
                    end
                    gnt_vid: begin
                        own_d      = OWN_VID;
                        mem_ce_d   = 1'b1;
                        mem_addr_d = AW'({4'h9, vid_a});
                        rd_d       = 1'b1;
                        unm_d      = 1'b0;
                        state_d    = S_ACC;
                    end
                    gnt_cpu: begin
                        own_d      = OWN_CPU;
                        mem_ce_d   = cpu_ce;
                        mem_we_d   = cpu_ce && cpu_w;
                        mem_addr_d = cpu_maddr;
                        mem_din_d  = cpu_d;
                        rd_d       = !cpu_w;
                        unm_d      = !cpu_map;
                        state_d    = S_ACC;
                    end
                    default: ;
                endcase
            end
            S_ACC: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                state_d = S_IDLE;
                unique case (own_q)
                    OWN_VID: begin
                        vid_dout_d = bus.mem_dout;
                        vid_ack_d  = 1'b1;
                    end
                    OWN_CPU: begin
                        cpu_ack_d = 1'b1;
                        if (rd_q) begin
                            cpu_dout_d = unm_q ? UNMAPPED : bus.mem_dout;
                        end
                    end
                    default: ;
                endcase
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            own_q      <= OWN_LD;
            ld_flag_q  <= 1'b0;
            ld_addr_q  <= '0;
            ld_din_q   <= 8'h00;
            vid_flag_q <= 1'b0;
            vid_addr_q <= 8'h00;
            cpu_flag_q <= 1'b0;
            cpu_addr_q <= 16'h0000;
            cpu_din_q  <= 8'h00;
            cpu_we_q   <= 1'b0;
            mem_ce_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= 8'h00;
            rd_q       <= 1'b0;
            unm_q      <= 1'b0;
            vid_dout_q <= 8'h00;
            vid_ack_q  <= 1'b0;
            cpu_dout_q <= 8'hFF;
            cpu_ack_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            ld_flag_q  <= ld_flag_d;
            ld_addr_q  <= ld_addr_d;
            ld_din_q   <= ld_din_d;
            vid_flag_q <= vid_flag_d;
            vid_addr_q <= vid_addr_d;
            cpu_flag_q <= cpu_flag_d;
            cpu_addr_q <= cpu_addr_d;
            cpu_din_q  <= cpu_din_d;
            cpu_we_q   <= cpu_we_d;
            mem_ce_q   <= mem_ce_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rd_q       <= rd_d;
            unm_q      <= unm_d;
            vid_dout_q <= vid_dout_d;
            vid_ack_q  <= vid_ack_d;
            cpu_dout_q <= cpu_dout_d;
            cpu_ack_q  <= cpu_ack_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.mem_ce   = mem_ce_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
    assign bus.vid_dout = vid_dout_q;
    assign bus.vid_ack  = vid_ack_q;
    assign bus.cpu_dout = cpu_dout_q;
    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.ovf      = ovf_q;

    // Stall from request until the ack cycle, and for the whole download
    assign bus.cpu_wait_n = !(cpu_flag_q ||
                              ((own_q == OWN_CPU) && !idle) ||
                              bus.ld_en);

endmodule
